// File: rtl/b06_eql_requester.sv
// b06_eql_requester: peer side of the b06 EQL/ACKOUT handshake, counts enables against a target
module b06_eql_requester #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_in_i,
  input  logic [CNT_W-1:0] req_target_i,
  input  logic             ackout_i,
  input  logic             enable_count_i,
  input  logic [1:0]       cc_mux_i,
  input  logic [1:0]       uscite_i,
  output logic             eql_o,
  output logic             cont_eql_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       result_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] count_o
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_COUNT, S_RELEASE} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, target_q, target_d;
  logic [7:0]       timer_q, timer_d;
  logic [3:0]       result_q, result_d;
  logic             tmo_q, tmo_d;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      target_q <= '0;
      timer_q  <= '0;
      result_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
    end
  end
  // next state; acknowledge wins over timeout, the count still steps on the ack-drop cycle
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    timer_d  = timer_q;
    result_d = result_q;
    tmo_d    = 1'b0;
    case (state_q)
      S_IDLE: if (req_in_i) begin
        target_d = req_target_i;
        count_d  = '0;
        timer_d  = '0;
        state_d  = S_ASSERT;
      end
      S_ASSERT: if (ackout_i) begin
        state_d = S_COUNT;
        timer_d = '0;
      end else if (timer_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = 1'b1;
      end else timer_d = timer_q + 8'd1;
      S_COUNT: begin
        if (enable_count_i && count_q != '1) count_d = count_q + 1'b1;
        if (!ackout_i) begin
          result_d = {cc_mux_i, uscite_i};
          state_d  = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // outputs decoded from registers only
  always_comb begin
    eql_o         = state_q == S_ASSERT || state_q == S_COUNT;
    busy_o        = state_q != S_IDLE;
    done_o        = state_q == S_RELEASE;
    cont_eql_o    = (state_q == S_COUNT || state_q == S_RELEASE) && count_q == target_q;
    timeout_err_o = tmo_q;
    count_o       = count_q;
    result_o      = result_q;
  end
endmodule

// File: tb/tb_b06_eql_requester.sv
// tb_b06_eql_requester: directed checks of the b06 EQL requester handshake
module tb_b06_eql_requester;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_in = 1'b0;
  logic [3:0] req_target = '0;
  logic       ackout = 1'b0;
  logic       enable_count = 1'b0;
  logic [1:0] cc_mux = '0;
  logic [1:0] uscite = '0;
  logic       eql, cont_eql, busy, done, timeout_err;
  logic [3:0] result, count;
  int         checks = 0;
  int         passes = 0;

  b06_eql_requester #(.CNT_W(4), .TIMEOUT(15)) dut (
    .clock_i(clk), .reset_i(rst), .req_in_i(req_in), .req_target_i(req_target),
    .ackout_i(ackout), .enable_count_i(enable_count), .cc_mux_i(cc_mux), .uscite_i(uscite),
    .eql_o(eql), .cont_eql_o(cont_eql), .busy_o(busy), .done_o(done),
    .result_o(result), .timeout_err_o(timeout_err), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // f = {eql, cont_eql, busy, done, timeout_err}
  task automatic chk(input string tag, input logic [4:0] f, input logic [3:0] c, input logic [3:0] r);
    logic [12:0] obs, exp;
    obs = {eql, cont_eql, busy, done, timeout_err, count, result};
    exp = {f, c, r};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("reset", 5'b00000, 4'd0, 4'h0);
    rst = 1'b0;
    // normal transaction, target 3
    req_in = 1'b1; req_target = 4'd3;
    tick(); chk("norm_assert1", 5'b10100, 4'd0, 4'h0);
    req_in = 1'b0;
    tick(); chk("norm_assert2", 5'b10100, 4'd0, 4'h0);
    ackout = 1'b1;
    tick(); chk("norm_count0", 5'b10100, 4'd0, 4'h0);
    enable_count = 1'b1;
    tick(); chk("norm_count1", 5'b10100, 4'd1, 4'h0);
    tick(); chk("norm_count2", 5'b10100, 4'd2, 4'h0);
    tick(); chk("norm_count3", 5'b11100, 4'd3, 4'h0);
    enable_count = 1'b0;
    tick(); chk("norm_hold3", 5'b11100, 4'd3, 4'h0);
    ackout = 1'b0; cc_mux = 2'b01; uscite = 2'b10;
    tick(); chk("norm_release", 5'b01110, 4'd3, 4'h6);
    cc_mux = 2'b00; uscite = 2'b00;
    tick(); chk("norm_idle", 5'b00000, 4'd3, 4'h6);
    // timeout with ACKOUT held low
    req_in = 1'b1; req_target = 4'd4;
    tick(); chk("tmo_assert1", 5'b10100, 4'd0, 4'h6);
    req_in = 1'b0;
    repeat (14) tick();
    chk("tmo_assert15", 5'b10100, 4'd0, 4'h6);
    tick(); chk("tmo_pulse", 5'b00001, 4'd0, 4'h6);
    tick(); chk("tmo_after", 5'b00000, 4'd0, 4'h6);
    // requests outside IDLE are ignored
    req_in = 1'b1; req_target = 4'd5;
    tick(); chk("ign_assert1", 5'b10100, 4'd0, 4'h6);
    req_target = 4'd9;
    tick(); chk("ign_assert2", 5'b10100, 4'd0, 4'h6);
    req_in = 1'b0; ackout = 1'b1;
    tick(); chk("ign_count0", 5'b10100, 4'd0, 4'h6);
    req_in = 1'b1; req_target = 4'd0;
    tick(); chk("ign_count_req", 5'b10100, 4'd0, 4'h6);
    req_in = 1'b0; enable_count = 1'b1;
    repeat (5) tick();
    chk("ign_count5", 5'b11100, 4'd5, 4'h6);
    enable_count = 1'b0; ackout = 1'b0; cc_mux = 2'b11; uscite = 2'b01;
    req_in = 1'b1; req_target = 4'd7;
    tick(); chk("ign_release", 5'b01110, 4'd5, 4'hD);
    cc_mux = 2'b00; uscite = 2'b00;
    tick(); chk("ign_idle", 5'b00000, 4'd5, 4'hD);
    tick(); chk("idle_req_accept", 5'b10100, 4'd0, 4'hD);
    // ACKOUT arriving on exactly the 15th ASSERT cycle
    req_in = 1'b0;
    repeat (14) tick();
    chk("edge_assert15", 5'b10100, 4'd0, 4'hD);
    ackout = 1'b1;
    tick(); chk("edge_count0", 5'b10100, 4'd0, 4'hD);
    enable_count = 1'b1;
    repeat (7) tick();
    chk("edge_count7", 5'b11100, 4'd7, 4'hD);
    enable_count = 1'b0; ackout = 1'b0; cc_mux = 2'b10;
    tick(); chk("edge_release", 5'b01110, 4'd7, 4'h8);
    cc_mux = 2'b00;
    tick(); chk("edge_idle", 5'b00000, 4'd7, 4'h8);
    // saturation at target 15
    req_in = 1'b1; req_target = 4'd15;
    tick(); chk("sat_assert", 5'b10100, 4'd0, 4'h8);
    req_in = 1'b0; ackout = 1'b1;
    tick(); chk("sat_count0", 5'b10100, 4'd0, 4'h8);
    enable_count = 1'b1;
    repeat (20) tick();
    chk("sat_count20", 5'b11100, 4'd15, 4'h8);
    ackout = 1'b0; cc_mux = 2'b01; uscite = 2'b11;
    tick(); chk("sat_release", 5'b01110, 4'd15, 4'h7);
    enable_count = 1'b0; cc_mux = 2'b00; uscite = 2'b00;
    tick(); chk("sat_idle", 5'b00000, 4'd15, 4'h7);
    // asynchronous reset in COUNT with count 5
    req_in = 1'b1; req_target = 4'd9;
    tick(); chk("rst_assert", 5'b10100, 4'd0, 4'h7);
    req_in = 1'b0; ackout = 1'b1;
    tick();
    enable_count = 1'b1;
    repeat (5) tick();
    chk("rst_count5", 5'b10100, 4'd5, 4'h7);
    enable_count = 1'b0;
    #3 rst = 1'b1;
    #1 chk("rst_async", 5'b00000, 4'd0, 4'h0);
    ackout = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_held", 5'b00000, 4'd0, 4'h0);
    // zero target, ack drop with enable on the first COUNT cycle
    req_in = 1'b1; req_target = 4'd0;
    tick(); chk("zero_assert", 5'b10100, 4'd0, 4'h0);
    req_in = 1'b0; ackout = 1'b1;
    tick(); chk("zero_count0", 5'b11100, 4'd0, 4'h0);
    ackout = 1'b0; enable_count = 1'b1; cc_mux = 2'b10; uscite = 2'b11;
    tick(); chk("zero_release", 5'b00110, 4'd1, 4'hB);
    enable_count = 1'b0; cc_mux = 2'b00; uscite = 2'b00;
    tick(); chk("zero_idle", 5'b00000, 4'd1, 4'hB);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
